memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Arbitrates one instruction port and one data port onto a single RAM.
// Bounded data streak, wait timeout and a sticky error flag.
module memory_arbiter #(
    parameter int DSTREAK_MAX = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        mem_err
);

    localparam int SW = (DSTREAK_MAX < 1) ? 1 : $clog2(DSTREAK_MAX + 1);
    localparam int WW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(DSTREAK_MAX);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          mem_err_q, mem_err_d;
    logic          d_req;
    logic          access_req;

    assign d_req   = dREN | dWEN;
    assign mem_err = mem_err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
        end
    end

    // The wait counter defaults to zero so that every state change restarts it.
    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        wait_d     = '0;
        mem_err_d  = mem_err_q;
        access_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (!iREN) begin
                    streak_d = '0;
                end
                if (d_req && ((streak_q < STREAK_MAX) || !iREN)) begin
                    state_d = DACC;
                    if (iREN && (streak_q < STREAK_MAX)) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (iREN) begin
                    state_d  = IACC;
                    streak_d = '0;
                end
            end
            IACC, DACC: begin
                access_req = (state_q == IACC) ? iREN : d_req;
                if (!access_req || (ramstate == RAM_ACCESS)) begin
                    state_d = IDLE;
                end else if ((ramstate == RAM_ERROR) || (wait_q == WAIT_LAST)) begin
                    state_d   = IDLE;
                    mem_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ihit     = 1'b0;
        dhit     = 1'b0;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (iREN && (ramstate == RAM_ACCESS)) begin
                    ihit  = 1'b1;
                    iload = ramload;
                end
            end
            DACC: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (d_req && (ramstate == RAM_ACCESS)) begin
                    dhit  = 1'b1;
                    dload = dWEN ? 32'd0 : ramload;
                end
            end
            default: ;
        endcase
    end

endmodule
